dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 43 ++++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dmem_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int DEPTH_DEF   = 256;
    localparam int LATENCY_DEF = 2;
    localparam int CNT_W       = 4;   // holds LATENCY-1 for LATENCY up to 15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read.
// Latency: read data valid one edge after en_i with we_i = 0.
// Backpressure: none; the read register holds until the next en_i/clr_i.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset: contents survive a responder reset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register: loads on a read, returns zero for a write or a cleared access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i];
        end else if (en_i || clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one request, waits LATENCY cycles, presents a held response.
// Latency: response valid LATENCY+1 samples after the accept edge; request period LATENCY+2 minimum.
// Backpressure: response held stable until resp_ready_i; optional misalign check via DMEM_MISALIGN_CHK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mis_q;
    logic              err_q;

    logic              accept;
    logic              enter_resp;
    logic              from_in;
    logic              mis_in;
    logic              acc_we;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_mis;
    logic              unused_addr;

    assign accept = req_valid_i && (state_q == ST_IDLE);

`ifdef DMEM_MISALIGN_CHK_EN
    assign mis_in = |req_addr_i[1:0];
`else
    assign mis_in = 1'b0;
`endif

    // Upper address bits wrap modulo DEPTH; byte offset only matters to the misalign check.
    assign unused_addr = ^{req_addr_i[ADDR_W-1:IDX_W+2], req_addr_i[1:0]};

    // State and wait-counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; with zero latency the accept edge itself is the access edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        from_in    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (LATENCY == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                        from_in    = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the request on the accept edge only; later input changes are ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we_i;
            idx_q   <= req_addr_i[IDX_W+1:2];
            wdata_q <= req_wdata_i;
            mis_q   <= mis_in;
        end
    end

    assign acc_we    = from_in ? req_we_i                : we_q;
    assign acc_idx   = from_in ? req_addr_i[IDX_W+1:2]   : idx_q;
    assign acc_wdata = from_in ? req_wdata_i             : wdata_q;
    assign acc_mis   = from_in ? mis_in                  : mis_q;

    // Error flag is registered alongside the array access and held through RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= acc_mis;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (enter_resp && !acc_mis),
        .we_i    (acc_we),
        .clr_i   (enter_resp && acc_mis),
        .idx_i   (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (resp_rdata_o)
    );

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_err_o   = err_q;
    assign busy_o       = (state_q != ST_IDLE) || req_valid_i;

endmodule
